// File: rtl/fir_sequencer.sv
// Single-clock control path for the distributed-arithmetic FIR: it arbitrates coefficient writes
// against samples, runs one DA pass per sample with a timeout, and holds each result for the sink.
module fir_sequencer #(
    parameter int unsigned DIN_W   = 16,
    parameter int unsigned ACC_W   = 39,
    parameter int unsigned COEF_W  = 20,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              CLOAD,
    output logic [ADDR_W-1:0] CADDR,
    output logic [COEF_W-1:0] CIN,
    output logic              fifo_load,
    output logic [DIN_W-1:0]  fifo_w,
    output logic              da_reset,
    output logic              da_start,
    input  logic              da_done,
    input  logic [ACC_W-1:0]  acc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_cnt;
    logic              r_cload;
    logic [ADDR_W-1:0] r_caddr;
    logic [COEF_W-1:0] r_cin;
    logic              r_fifo_load;
    logic [DIN_W-1:0]  r_fifo_w;
    logic              r_da_reset;
    logic              r_da_start;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_data;
    logic              r_err;
    logic              w_cfg_acc;
    logic              w_in_acc;
    logic              w_timeout;

    assign w_cfg_acc = cfg_valid & cfg_ready;
    assign w_in_acc  = in_valid & in_ready;
    // A done arriving on the timeout cycle wins over the timeout.
    assign w_timeout = (r_state == RUN) && !da_done && (r_cnt == TO_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_acc) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: w_state_next = RUN;
            RUN: begin
                if (da_done) begin
                    w_state_next = HOLD;
                end else if (w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        if (!reset && r_state == IDLE) begin
            cfg_ready = cfg_valid;
            in_ready  = ~cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cload     <= 1'b0;
            r_caddr     <= '0;
            r_cin       <= '0;
            r_fifo_load <= 1'b0;
            r_fifo_w    <= '0;
            r_da_reset  <= 1'b1;
            r_da_start  <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cload     <= w_cfg_acc;
            r_fifo_load <= w_in_acc;
            r_da_reset  <= w_in_acc;
            r_da_start  <= (r_state == CLEAR);
            if (w_cfg_acc) begin
                r_caddr <= cfg_addr;
                r_cin   <= cfg_data;
            end
            if (w_in_acc) begin
                r_fifo_w <= in_data;
            end
            if (r_state == CLEAR) begin
                r_cnt <= 8'd1;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == RUN && da_done) begin
                r_out_data  <= acc_in;
                r_out_valid <= 1'b1;
            end else if (r_state == HOLD && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign CLOAD     = r_cload;
    assign CADDR     = r_caddr;
    assign CIN       = r_cin;
    assign fifo_load = r_fifo_load;
    assign fifo_w    = r_fifo_w;
    assign da_reset  = r_da_reset;
    assign da_start  = r_da_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;
endmodule
